cdc_handshake_arbiter: RTL and testbench

// Shares one cdc_handshake channel between REQ_CNT requesters that all live in
// the channel's master clock domain. It grants one requester at a time in

---
 rtl/cdc_handshake_arbiter.sv | 120 ++++++++++++
 tb/tb_cdc_handshake_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_arbiter.sv
// Round-robin arbiter that shares one cdc_handshake channel among REQ_CNT master-domain requesters.
// Optional WAIT-state watchdog (sticky timeout_o) is enabled by defining CDC_ARB_TIMEOUT_EN.
module cdc_handshake_arbiter #(
  parameter int REQ_CNT        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SEL_W         = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [REQ_CNT-1:0]            req_i,
  input  logic [REQ_CNT*DATA_WIDTH-1:0] data_i,
  output logic [REQ_CNT-1:0]            ack_o,
  output logic                          busy_o,
  output logic                          hs_req_o,
  input  logic                          hs_ack_i,
  output logic [DATA_WIDTH-1:0]         hs_data_o,
  output logic [SEL_W-1:0]              hs_sel_o
`ifdef CDC_ARB_TIMEOUT_EN
  ,
  output logic                          timeout_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_found;
  int               scan_idx;

  // Search starts at the pointer and wraps, so the last winner is scanned last.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int i = 0; i < REQ_CNT; i++) begin
      scan_idx = (int'(ptr_q) + i) % REQ_CNT;
      if (!grant_found && req_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = SEL_W'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (hs_ack_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Grant latch and round-robin pointer; the payload register is reset so outputs read 0 after rst_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      hs_sel_o  <= '0;
      hs_data_o <= '0;
    end else begin
      if (state_q == S_IDLE && grant_found) begin
        hs_sel_o  <= grant_idx;
        hs_data_o <= data_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state_q == S_DONE) begin
        ptr_q <= SEL_W'((int'(hs_sel_o) + 1) % REQ_CNT);
      end
    end
  end

  always_comb begin
    ack_o    = '0;
    hs_req_o = (state_q == S_ISSUE);
    busy_o   = (state_q != S_IDLE);
    if (state_q == S_DONE) ack_o[hs_sel_o] = 1'b1;
  end

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;

  // Watchdog only flags a stuck channel; the FSM keeps waiting to stay in step with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == S_ISSUE) begin
        wait_cnt_q <= '0;
      end else if (state_q == S_WAIT && int'(wait_cnt_q) < TIMEOUT_CYCLES) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (state_q == S_WAIT && int'(wait_cnt_q) >= TIMEOUT_CYCLES - 1) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// Self-checking bench for cdc_handshake_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model. Timeout scenario needs CDC_ARB_TIMEOUT_EN.
module tb_cdc_handshake_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_v;
  logic [N*W-1:0] data_bus;
  logic [N-1:0]   ack;
  logic           busy;
  logic           hs_req;
  logic           hs_ack;
  logic [W-1:0]   hs_data;
  logic [1:0]     hs_sel;
`ifdef CDC_ARB_TIMEOUT_EN
  logic           timeout;
`endif

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;

  cdc_handshake_arbiter #(
    .REQ_CNT       (N),
    .DATA_WIDTH    (W),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req_v),
    .data_i   (data_bus),
    .ack_o    (ack),
    .busy_o   (busy),
    .hs_req_o (hs_req),
    .hs_ack_i (hs_ack),
    .hs_data_o(hs_data),
    .hs_sel_o (hs_sel)
`ifdef CDC_ARB_TIMEOUT_EN
    ,
    .timeout_o(timeout)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first pending requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!hs_req && cyc < 20);
    check("grant_seen", {63'd0, hs_req}, 64'd1);
  endtask

  // One full transaction: grant, lat WAIT cycles, completion pulse, ack.
  task automatic do_txn(input int lat, input bit mutate, output int win, output int cyc);
    logic [W-1:0] exp_d;
    logic [N-1:0] exp_ack;
    win     = rr_pick(req_v, ptr_m);
    exp_d   = data_bus[win*W +: W];
    exp_ack = '0;
    exp_ack[win] = 1'b1;
    wait_grant(cyc);
    check("sel", 64'(hs_sel), 64'(win));
    check("data", 64'(hs_data), 64'(exp_d));
    check("busy", {63'd0, busy}, 64'd1);
    check("ack_in_issue", 64'(ack), 64'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("no_req_in_wait", {63'd0, hs_req}, 64'd0);
      check("no_ack_in_wait", 64'(ack), 64'd0);
      if (mutate && k == 1) begin
        data_bus[win*W +: W] = ~exp_d;
        req_v[win] = 1'b0;
      end
    end
    hs_ack = 1'b1;
    @(negedge clk);
    hs_ack = 1'b0;
    check("ack", 64'(ack), 64'(exp_ack));
    check("data_done", 64'(hs_data), 64'(exp_d));
    check("no_req_in_done", {63'd0, hs_req}, 64'd0);
    ptr_m = (win + 1) % N;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    ptr_m = 0;
  endtask

  initial begin
    int win;
    int cyc;
    int order[5];
    int fair[3];
    logic [N-1:0] nb;

    order = '{0, 1, 2, 3, 0};
    fair  = '{1, 3, 1};
    rst      = 1'b1;
    req_v    = '0;
    hs_ack   = 1'b0;
    data_bus = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hs_req", {63'd0, hs_req}, 64'd0);
    check("rst_hs_data", 64'(hs_data), 64'd0);
    check("rst_hs_sel", 64'(hs_sel), 64'd0);
`ifdef CDC_ARB_TIMEOUT_EN
    check("rst_timeout", {63'd0, timeout}, 64'd0);
`endif
    rst = 1'b0;

    // Single request from requester 2, channel answers 6 cycles after hs_req_o
    req_v = 4'b0100;
    data_bus[2*W +: W] = 32'hA5A5_0002;
    do_txn(6, 1'b0, win, cyc);
    req_v = '0;
    check("single_latency", 64'(cyc), 64'd1);
    check("single_win", 64'(win), 64'd2);

    // All four requesting from reset: 0,1,2,3,0
    rst = 1'b1;
    for (int j = 0; j < N; j++) data_bus[j*W +: W] = $urandom;
    req_v = 4'b1111;
    @(negedge clk);
    rst   = 1'b0;
    ptr_m = 0;
    for (int t = 0; t < 5; t++) begin
      do_txn($urandom_range(1, 4), 1'b0, win, cyc);
      check("order", 64'(win), 64'(order[t]));
    end
    req_v = '0;

    // Fairness: 1 stays requesting through its ack while 3 is pending
    req_v = 4'b1010;
    for (int t = 0; t < 3; t++) begin
      do_txn($urandom_range(1, 4), 1'b0, win, cyc);
      check("fair", 64'(win), 64'(fair[t]));
    end
    req_v = '0;

    // Payload stability: data and req of requester 0 change during WAIT
    data_bus[0 +: W] = $urandom;
    req_v = 4'b0001;
    do_txn(3, 1'b1, win, cyc);
    check("stab_win", 64'(win), 64'd0);
    req_v = '0;

    // Reset during WAIT, then a stale completion pulse
    req_v = 4'b0001;
    wait_grant(cyc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    req_v  = '0;
    ptr_m  = 0;
    check("rstw_busy", {63'd0, busy}, 64'd0);
    check("rstw_hs_data", 64'(hs_data), 64'd0);
    check("rstw_hs_sel", 64'(hs_sel), 64'd0);
    hs_ack = 1'b1;
    @(negedge clk);
    hs_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rstw_ack", 64'(ack), 64'd0);
      check("rstw_idle", {62'd0, busy, hs_req}, 64'd0);
      @(negedge clk);
    end

    // Randomized traffic against the round-robin model
    for (int t = 0; t < 24; t++) begin
      nb = 4'($urandom_range(0, 15)) & ~req_v;
      if ((req_v | nb) == '0) nb[$urandom_range(0, N - 1)] = 1'b1;
      for (int j = 0; j < N; j++) begin
        if (nb[j]) data_bus[j*W +: W] = $urandom;
      end
      req_v = req_v | nb;
      do_txn($urandom_range(1, 5), 1'b0, win, cyc);
      if ($urandom_range(0, 1) == 1) req_v[win] = 1'b0;
    end
    req_v = '0;
    @(negedge clk);

`ifdef CDC_ARB_TIMEOUT_EN
    // Watchdog with TIMEOUT_CYCLES=8: flag appears after 8 WAIT cycles and is sticky
    apply_reset();
    req_v = 4'b0001;
    wait_grant(cyc);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("timeout_early", {63'd0, timeout}, 64'd0);
    end
    @(negedge clk);
    check("timeout_set", {63'd0, timeout}, 64'd1);
    hs_ack = 1'b1;
    @(negedge clk);
    hs_ack = 1'b0;
    req_v  = '0;
    check("timeout_ack", 64'(ack), 64'd1);
    repeat (2) @(negedge clk);
    check("timeout_sticky", {63'd0, timeout}, 64'd1);
    apply_reset();
    check("timeout_cleared", {63'd0, timeout}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
